// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: 3-entry EX/MEM/WB scoreboard, RAW stalls, EX bubbles, optional forwarding (HAZARD_CTRL_FORWARDING_EN).
// Latency: stall_*/bubble_ex combinational from inputs and scoreboard; fwd selects registered into the consumer's EX cycle.
// Backpressure: mem_busy freezes scoreboard, fwd selects and counter while holding fetch/decode.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid_i,
    input  logic [2:0]  id_rs_i,
    input  logic        id_rs_used_i,
    input  logic [2:0]  id_rt_i,
    input  logic        id_rt_used_i,
    input  logic        id_wr_en_i,
    input  logic [2:0]  id_wr_reg_i,
    input  logic        id_is_load_i,
    input  logic        mem_busy_i,
    input  logic        flush_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        bubble_ex_o,
    output logic [1:0]  fwd_a_sel_o,
    output logic [1:0]  fwd_b_sel_o,
    output logic [15:0] hazard_cnt_o
);
    // An entry's valid bit is only set for instructions that write a register.
    logic        ex_vld_q, mem_vld_q;
    logic [2:0]  ex_reg_q, mem_reg_q;
    logic [15:0] hazard_cnt_q, hazard_cnt_d;
    logic        rs_req, rt_req;
    logic        rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
    logic        hazard, insert;

    assign rs_req     = id_valid_i & id_rs_used_i;
    assign rt_req     = id_valid_i & id_rt_used_i;
    assign rs_hit_ex  = rs_req & ex_vld_q  & (id_rs_i == ex_reg_q);
    assign rt_hit_ex  = rt_req & ex_vld_q  & (id_rt_i == ex_reg_q);
    assign rs_hit_mem = rs_req & mem_vld_q & (id_rs_i == mem_reg_q);
    assign rt_hit_mem = rt_req & mem_vld_q & (id_rt_i == mem_reg_q);

    assign insert      = id_valid_i & ~hazard & ~flush_i;
    assign stall_if_o  = hazard | mem_busy_i;
    assign stall_id_o  = hazard | mem_busy_i;
    assign bubble_ex_o = (hazard | flush_i) & ~mem_busy_i & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_vld_q  <= 1'b0;
            ex_reg_q  <= 3'd0;
            mem_vld_q <= 1'b0;
            mem_reg_q <= 3'd0;
        end else if (!mem_busy_i) begin
            mem_vld_q <= ex_vld_q;
            mem_reg_q <= ex_reg_q;
            ex_vld_q  <= insert & id_wr_en_i;
            if (insert) ex_reg_q <= id_wr_reg_i;
        end
    end

`ifdef HAZARD_CTRL_FORWARDING_EN
    // Only the EX entry's load flag matters: later stages can always forward.
    logic       ex_load_q;
    logic [1:0] fwd_a_q, fwd_b_q;

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        return hit_ex ? 2'b01 : (hit_mem ? 2'b10 : 2'b00);
    endfunction

    assign hazard = ex_load_q & (rs_hit_ex | rt_hit_ex);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_load_q <= 1'b0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
        end else if (!mem_busy_i) begin
            ex_load_q <= insert & id_wr_en_i & id_is_load_i;
            fwd_a_q   <= insert ? fwd_sel(rs_hit_ex, rs_hit_mem) : 2'b00;
            fwd_b_q   <= insert ? fwd_sel(rt_hit_ex, rt_hit_mem) : 2'b00;
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
`else
    // No write-through in the register file, so a WB producer still blocks.
    logic       wb_vld_q;
    logic [2:0] wb_reg_q;
    logic       rs_hit_wb, rt_hit_wb;
    logic       unused_is_load;

    assign unused_is_load = id_is_load_i;
    assign rs_hit_wb = rs_req & wb_vld_q & (id_rs_i == wb_reg_q);
    assign rt_hit_wb = rt_req & wb_vld_q & (id_rt_i == wb_reg_q);
    assign hazard    = rs_hit_ex | rt_hit_ex | rs_hit_mem | rt_hit_mem | rs_hit_wb | rt_hit_wb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_vld_q <= 1'b0;
            wb_reg_q <= 3'd0;
        end else if (!mem_busy_i) begin
            wb_vld_q <= mem_vld_q;
            wb_reg_q <= mem_reg_q;
        end
    end

    assign fwd_a_sel_o = 2'b00;
    assign fwd_b_sel_o = 2'b00;
`endif

    assign hazard_cnt_d = (hazard && !mem_busy_i && hazard_cnt_q != 16'hFFFF)
                        ? hazard_cnt_q + 16'd1 : hazard_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hazard_cnt_q <= 16'd0;
        else         hazard_cnt_q <= hazard_cnt_d;
    end

    assign hazard_cnt_o = hazard_cnt_q;
endmodule
